// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame engine.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
`ifdef UART_TX_BREAK_EN
      ,
      BREAK
`endif
   } state_e;

   localparam logic [1:0] SEL_START = 2'b00;
   localparam logic [1:0] SEL_STOP  = 2'b01;
   localparam logic [1:0] SEL_DATA  = 2'b10;
   localparam logic [1:0] SEL_PAR   = 2'b11;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even parity is the XOR of all payload bits,
// odd parity is its inverse.
module uart_tx_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_typ_i,
   output logic                  parity_o
);

   assign parity_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start / LSB-first data / optional parity / stop bits,
// paced by an external baud_tick strobe. Define UART_TX_BREAK_EN to add break_req and BREAK.
module uart_tx_frame
   import uart_tx_pkg::*;
#(
   parameter int   DATA_WIDTH = 8,
   parameter int   STOP_BITS  = 1,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  baud_tick,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
`ifdef UART_TX_BREAK_EN
   input  logic                  break_req,
`endif
   output logic                  tx_out,
   output logic                  busy,
   output logic [1:0]            mux_sel
);

   localparam int               CNT_W     = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_tx_frame: DATA_WIDTH must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic [1:0]            sel_q, sel_d;
   logic                  parity_bit;
   logic                  last_stop_tick;
   logic                  accept;

   uart_tx_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data_i    (data_q),
      .par_typ_i (par_typ_q),
      .parity_o  (parity_bit)
   );

   // A new payload is taken either from IDLE or on the closing tick of STOP.
   assign last_stop_tick = (state_q == STOP) && baud_tick && (stop_cnt_q == LAST_STOP);
   assign accept         = data_valid && ((state_q == IDLE) || last_stop_tick);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
            end
`ifdef UART_TX_BREAK_EN
            else if (break_req) begin
               state_d = BREAK;
            end
`endif
         end
         START: begin
            if (baud_tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_d    = par_en_q ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (baud_tick) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (last_stop_tick) begin
               state_d = accept ? START : IDLE;
            end else if (baud_tick) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_BREAK_EN
         BREAK: begin
            if (baud_tick && !break_req) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      if (accept) begin
         data_d    = p_data;
         par_en_d  = par_en;
         par_typ_d = par_typ;
      end
   end

   // Line level and select code follow the next state so they switch with it.
   always_comb begin
      tx_d   = IDLE_LEVEL;
      sel_d  = SEL_STOP;
      busy_d = 1'b1;
      case (state_d)
         IDLE:    busy_d = 1'b0;
         START: begin
            tx_d  = 1'b0;
            sel_d = SEL_START;
         end
         DATA: begin
            tx_d  = data_d[bit_cnt_d];
            sel_d = SEL_DATA;
         end
         PARITY: begin
            tx_d  = parity_bit;
            sel_d = SEL_PAR;
         end
         STOP:    busy_d = 1'b1;
`ifdef UART_TX_BREAK_EN
         BREAK: begin
            tx_d  = 1'b0;
            sel_d = SEL_START;
         end
`endif
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         tx_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         sel_q      <= SEL_STOP;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         sel_q      <= sel_d;
      end
   end

   assign tx_out  = tx_q;
   assign busy    = busy_q;
   assign mux_sel = sel_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus queues the expected line state per bit
// period, a monitor per instance samples after every baud tick and compares.
module tb_uart_tx_frame;
   import uart_tx_pkg::*;

   typedef struct packed {
      logic       tx;
      logic       busy;
      logic [1:0] sel;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud_tick = 1'b0;
   logic [7:0] p_data1 = '0;
   logic [7:0] p_data2 = '0;
   logic       dv1 = 1'b0;
   logic       dv2 = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx1, busy1, tx2, busy2;
   logic [1:0] sel1, sel2;
`ifdef UART_TX_BREAK_EN
   logic       break_req = 1'b0;
`endif

   obs_t q1[$];
   obs_t q2[$];
   int   n_checks = 0;
   int   n_fail = 0;

   uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1), .IDLE_LEVEL(1'b1)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick  (baud_tick),
      .p_data     (p_data1),
      .data_valid (dv1),
      .par_en     (par_en),
      .par_typ    (par_typ),
`ifdef UART_TX_BREAK_EN
      .break_req  (break_req),
`endif
      .tx_out     (tx1),
      .busy       (busy1),
      .mux_sel    (sel1)
   );

   uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2), .IDLE_LEVEL(1'b1)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick  (baud_tick),
      .p_data     (p_data2),
      .data_valid (dv2),
      .par_en     (par_en),
      .par_typ    (par_typ),
`ifdef UART_TX_BREAK_EN
      .break_req  (1'b0),
`endif
      .tx_out     (tx2),
      .busy       (busy2),
      .mux_sel    (sel2)
   );

   initial forever #5 clk = ~clk;

   // One-cycle tick on every fourth rising edge.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph + 1) % 4;
         baud_tick = (ph == 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(string name, obs_t act, obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got tx=%b busy=%b sel=%b, want tx=%b busy=%b sel=%b",
                  name, act.tx, act.busy, act.sel, exp.tx, exp.busy, exp.sel);
      end
   endtask

   task automatic wait_tick();
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
   endtask

   // Returns two time units after the edge just before a tick edge.
   task automatic pre_tick();
      wait_tick();
      repeat (3) @(posedge clk);
      #2;
   endtask

   function automatic void push(int d, logic t, logic b, logic [1:0] s);
      obs_t e;
      e = '{tx: t, busy: b, sel: s};
      if (d == 1) q1.push_back(e);
      else        q2.push_back(e);
   endfunction

   function automatic void push_frame(int d, logic [7:0] data, logic pen, logic pbit,
                                      int stops, int idles);
      push(d, 1'b0, 1'b1, SEL_START);
      for (int i = 0; i < 8; i++) push(d, data[i], 1'b1, SEL_DATA);
      if (pen) push(d, pbit, 1'b1, SEL_PAR);
      for (int i = 0; i < stops; i++) push(d, 1'b1, 1'b1, SEL_STOP);
      for (int i = 0; i < idles; i++) push(d, 1'b1, 1'b0, SEL_STOP);
   endfunction

   task automatic send(int d, logic [7:0] data, logic pen, logic ptyp, logic pbit,
                       int stops, int idles, bit expect_it);
      pre_tick();
      par_en  = pen;
      par_typ = ptyp;
      if (d == 1) begin p_data1 = data; dv1 = 1'b1; end
      else        begin p_data2 = data; dv2 = 1'b1; end
      if (expect_it) push_frame(d, data, pen, pbit, stops, idles);
      @(posedge clk);
      #2;
      dv1 = 1'b0;
      dv2 = 1'b0;
   endtask

   task automatic drain(int d);
      int n;
      int left;
      n = 0;
      left = (d == 1) ? q1.size() : q2.size();
      while (left != 0 && n < 400) begin
         @(posedge clk);
         n++;
         left = (d == 1) ? q1.size() : q2.size();
      end
      n_checks++;
      if (left != 0) begin
         n_fail++;
         $display("FAIL drain dut%0d: %0d samples still pending, want 0", d, left);
      end
   endtask

   initial begin
      forever begin
         wait_tick();
         @(negedge clk);
         if (q1.size() != 0) check("dut1 bit", obs_t'({tx1, busy1, sel1}), q1.pop_front());
      end
   end

   initial begin
      forever begin
         wait_tick();
         @(negedge clk);
         if (q2.size() != 0) check("dut2 bit", obs_t'({tx2, busy2, sel2}), q2.pop_front());
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("reset dut1", obs_t'({tx1, busy1, sel1}), obs_t'({1'b1, 1'b0, SEL_STOP}));
      check("reset dut2", obs_t'({tx2, busy2, sel2}), obs_t'({1'b1, 1'b0, SEL_STOP}));
      rst_n = 1'b1;

      // A5 without parity: line 0,1,0,1,0,0,1,0,1,1 then idle.
      send(1, 8'hA5, 1'b0, PAR_EVEN, 1'b0, 1, 1, 1'b1);
      drain(1);

      // 07: even parity bit 1, odd parity bit 0.
      send(1, 8'h07, 1'b1, PAR_EVEN, 1'b1, 1, 1, 1'b1);
      drain(1);
      send(1, 8'h07, 1'b1, PAR_ODD, 1'b0, 1, 1, 1'b1);
      drain(1);

      // Two stop bits, back-to-back 55 then 0F with data_valid held.
      pre_tick();
      par_en  = 1'b0;
      p_data2 = 8'h55;
      dv2     = 1'b1;
      push_frame(2, 8'h55, 1'b0, 1'b0, 2, 0);
      push_frame(2, 8'h0F, 1'b0, 1'b0, 2, 1);
      wait_tick();
      #2;
      p_data2 = 8'h0F;
      repeat (11) wait_tick();
      #2;
      dv2 = 1'b0;
      drain(2);

      // data_valid pulse with FF mid-frame is ignored.
      send(1, 8'hA5, 1'b0, PAR_EVEN, 1'b0, 1, 2, 1'b1);
      wait_tick();
      pre_tick();
      p_data1 = 8'hFF;
      dv1     = 1'b1;
      @(posedge clk);
      #2;
      dv1     = 1'b0;
      p_data1 = 8'h00;
      drain(1);

      // Asynchronous reset during data bit 3.
      send(1, 8'h00, 1'b0, PAR_EVEN, 1'b0, 1, 1, 1'b0);
      repeat (4) wait_tick();
      #2;
      check("bit3 before reset", obs_t'({tx1, busy1, sel1}), obs_t'({1'b0, 1'b1, SEL_DATA}));
      rst_n = 1'b0;
      #1;
      check("async reset", obs_t'({tx1, busy1, sel1}), obs_t'({1'b1, 1'b0, SEL_STOP}));
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      send(1, 8'h3C, 1'b0, PAR_EVEN, 1'b0, 1, 1, 1'b1);
      drain(1);

`ifdef UART_TX_BREAK_EN
      // Break held for 20 ticks, line back to idle on the first tick after release.
      pre_tick();
      break_req = 1'b1;
      for (int i = 0; i < 20; i++) push(1, 1'b0, 1'b1, SEL_START);
      push(1, 1'b1, 1'b0, SEL_STOP);
      wait_tick();
      repeat (19) wait_tick();
      #2;
      break_req = 1'b0;
      drain(1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
